// File: rtl/trace_capture_buffer.sv
// Multi-lane execution trace recorder: circular capture around a trigger,
// frozen window streamed oldest-first over a valid/ready port.
`timescale 1ns/1ps
module trace_capture_buffer #(
    parameter int LANES     = 2,
    parameter int DEPTH     = 16,
    parameter int DW        = 32,
    parameter int POST_TRIG = 8,
    localparam int LW = 2 + 32 + DW,
    localparam int RW = 16 + LANES * LW,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               hz100,
    input  logic               reset,
    input  logic [LANES-1:0]   lane_valid,
    input  logic [LANES-1:0]   lane_freeze,
    input  logic [LANES*32-1:0] lane_ins,
    input  logic [LANES*DW-1:0] lane_result,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig,
    input  logic               filter_en,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [RW-1:0]      rd_data,
    output logic               rd_last,
    output logic [1:0]         state,
    output logic [CW-1:0]      count,
    output logic               overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     stamp_q, stamp_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   post_cnt_q, post_cnt_d;
    logic [CW-1:0]   rd_num_q, rd_num_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic [RW-1:0]   rd_data_q, rd_data_d;

    logic [RW-1:0]   mem_q [DEPTH];
    logic [RW-1:0]   sample;
    logic            wr_en;
    logic            keep;
    logic            full;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   rd_addr;

    // Lane 0 sits at the LSB end; the stamp occupies the top 16 bits.
    always_comb begin
        sample = '0;
        sample[RW-1 -: 16] = stamp_q;
        for (int i = 0; i < LANES; i++) begin
            sample[i*LW +: LW] = {lane_valid[i], lane_freeze[i],
                                  lane_ins[32*i +: 32],
                                  lane_result[DW*i +: DW]};
        end
    end

    assign keep    = !filter_en || (|lane_valid);
    assign full    = (count_q == CW'(DEPTH));
    assign oldest  = full ? wr_ptr_q : '0;
    assign rd_addr = oldest + rd_num_q[AW-1:0];

    always_comb begin
        state_d    = state_q;
        stamp_d    = stamp_q + 16'd1;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        post_cnt_d = post_cnt_q;
        rd_num_d   = rd_num_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;
        wr_en      = 1'b0;

        if (abort) begin
            state_d    = S_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d    = S_ARMED;
                        wr_ptr_d   = '0;
                        count_d    = '0;
                        overflow_d = 1'b0;
                        rd_num_d   = '0;
                    end
                end
                S_ARMED: begin
                    // The trigger sample bypasses the filter.
                    wr_en = trig || keep;
                    if (trig) begin
                        post_cnt_d = AW'(POST_TRIG);
                        state_d    = (POST_TRIG == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (keep) begin
                        wr_en      = 1'b1;
                        post_cnt_d = post_cnt_q - AW'(1);
                        if (post_cnt_q == AW'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rd_valid_q) begin
                        if (rd_ready) begin
                            rd_valid_d = 1'b0;
                            rd_last_d  = 1'b0;
                            rd_num_d   = rd_num_q + CW'(1);
                            if (rd_last_q) begin
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem_q[rd_addr];
                        rd_last_d  = (rd_num_q == count_q - CW'(1));
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            stamp_q    <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            post_cnt_q <= '0;
            rd_num_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            stamp_q    <= stamp_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            post_cnt_q <= post_cnt_d;
            rd_num_q   <= rd_num_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage carries no reset; reads are bounded by count.
    always_ff @(posedge hz100) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sample;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_last  = rd_last_q;
    assign state    = state_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Randomized bench for trace_capture_buffer with a queue-based
// capture/readout reference model.
`timescale 1ns/1ps
module tb_trace_capture_buffer;

    localparam int LANES     = 2;
    localparam int DEPTH     = 8;
    localparam int DW        = 32;
    localparam int POST_TRIG = 3;
    localparam int LW        = 2 + 32 + DW;
    localparam int RW        = 16 + LANES * LW;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic                hz100 = 1'b0;
    logic                reset = 1'b1;
    logic [LANES-1:0]    lane_valid = '0;
    logic [LANES-1:0]    lane_freeze = '0;
    logic [LANES*32-1:0] lane_ins = '0;
    logic [LANES*DW-1:0] lane_result = '0;
    logic                arm = 1'b0;
    logic                abort = 1'b0;
    logic                trig = 1'b0;
    logic                filter_en = 1'b0;
    logic                rd_ready = 1'b0;
    logic                rd_valid;
    logic [RW-1:0]       rd_data;
    logic                rd_last;
    logic [1:0]          state;
    logic [CW-1:0]       count;
    logic                overflow;

    trace_capture_buffer #(
        .LANES(LANES), .DEPTH(DEPTH), .DW(DW), .POST_TRIG(POST_TRIG)
    ) dut (
        .hz100(hz100), .reset(reset),
        .lane_valid(lane_valid), .lane_freeze(lane_freeze),
        .lane_ins(lane_ins), .lane_result(lane_result),
        .arm(arm), .abort(abort), .trig(trig), .filter_en(filter_en),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .state(state), .count(count),
        .overflow(overflow)
    );

    always #5 hz100 = ~hz100;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: captured window as a queue, oldest at index 0.
    logic [RW-1:0] q[$];
    int            m_state = 0;
    bit            m_ovf = 1'b0;
    logic [15:0]   m_stamp = '0;
    int            m_post = 0;
    bit            m_rdv = 1'b0;
    int            m_idx = 0;
    logic [RW-1:0] m_data = '0;
    bit            m_last = 1'b0;

    function automatic logic [RW-1:0] pack(input logic [15:0] st);
        logic [RW-1:0] r;
        r = '0;
        r[RW-1 -: 16] = st;
        for (int i = 0; i < LANES; i++)
            r[i*LW +: LW] = {lane_valid[i], lane_freeze[i],
                             lane_ins[32*i +: 32], lane_result[DW*i +: DW]};
        return r;
    endfunction

    task automatic push(input logic [RW-1:0] s);
        if (q.size() == DEPTH) begin
            void'(q.pop_front());
            m_ovf = 1'b1;
        end
        q.push_back(s);
    endtask

    task automatic step();
        logic [RW-1:0] s;
        s = pack(m_stamp);
        if (abort) begin
            m_state = 0;
            m_rdv = 1'b0;
        end else begin
            case (m_state)
                0: if (arm) begin
                    m_state = 1;
                    q.delete();
                    m_ovf = 1'b0;
                    m_idx = 0;
                end
                1: begin
                    if (trig || !filter_en || lane_valid != 0) push(s);
                    if (trig) begin
                        m_post = POST_TRIG;
                        m_state = (POST_TRIG == 0) ? 3 : 2;
                    end
                end
                2: if (!filter_en || lane_valid != 0) begin
                    push(s);
                    m_post--;
                    if (m_post == 0) m_state = 3;
                end
                default: begin
                    if (m_rdv) begin
                        if (rd_ready) begin
                            m_rdv = 1'b0;
                            if (m_last) m_state = 0;
                            m_idx++;
                        end
                    end else begin
                        m_rdv = 1'b1;
                        m_data = q[m_idx];
                        m_last = (m_idx == q.size() - 1);
                    end
                end
            endcase
        end
        m_stamp++;
        @(posedge hz100);
        #1;
    endtask

    task automatic rand_lanes(input logic [LANES-1:0] lv);
        lane_valid  = lv;
        lane_freeze = LANES'($urandom);
        lane_ins    = {$urandom, $urandom};
        lane_result = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        repeat (3) @(posedge hz100);
        @(negedge hz100);
        reset = 1'b0;
        m_stamp = '0;
        #1;
        n_cmp += 6;
        if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
        if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        if (rd_last !== 1'b0) begin n_bad++; $display("FAIL reset_rd_last: got %0b expected 0", rd_last); end
        if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
        for (int i = 0; i < 10; i++) begin
            rd_ready = 1'b1;
            trig = i[0];
            rand_lanes(LANES'($urandom));
            step();
            n_cmp += 3;
            if (state !== 2'd0) begin n_bad++; $display("FAIL idle_state: got %0d expected 0", state); end
            if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL idle_rd_valid: got %0b expected 0", rd_valid); end
            if (count !== '0) begin n_bad++; $display("FAIL idle_count: got %0d expected 0", count); end
        end
        trig = 1'b0;
        rd_ready = 1'b0;
    endtask

    // mode 0: always ready; mode 1: hold off 5 cycles, then toggle.
    task automatic test_drain(input int mode, input logic [15:0] tstamp,
                              input int tpos);
        int  got, cyc, low_cnt, expn;
        bit  seen;
        got = 0; cyc = 0; low_cnt = 0; seen = 1'b0;
        expn = q.size();
        while (m_state == 3 && cyc < 100) begin
            if (mode == 0) rd_ready = 1'b1;
            else if (low_cnt < 5) rd_ready = 1'b0;
            else rd_ready = ~rd_ready;
            if (m_rdv && rd_ready) got++;
            step();
            cyc++;
            if (m_rdv && mode == 1 && low_cnt < 5) low_cnt++;
            n_cmp++;
            if (rd_valid !== m_rdv) begin
                n_bad++;
                $display("FAIL drain_rd_valid: got %0b expected %0b idx %0d", rd_valid, m_rdv, m_idx);
            end
            if (m_rdv) begin
                n_cmp += 2;
                if (rd_data !== m_data) begin
                    n_bad++;
                    $display("FAIL drain_rd_data: got %0h expected %0h idx %0d", rd_data, m_data, m_idx);
                end
                if (rd_last !== m_last) begin
                    n_bad++;
                    $display("FAIL drain_rd_last: got %0b expected %0b idx %0d", rd_last, m_last, m_idx);
                end
                if (m_idx == tpos && !seen) begin
                    seen = 1'b1;
                    n_cmp++;
                    if (rd_data[RW-1 -: 16] !== tstamp) begin
                        n_bad++;
                        $display("FAIL trig_record_stamp: got %0h expected %0h", rd_data[RW-1 -: 16], tstamp);
                    end
                end
            end
        end
        rd_ready = 1'b0;
        n_cmp += 4;
        if (cyc >= 100) begin n_bad++; $display("FAIL drain_timeout: got %0d cycles expected < 100", cyc); end
        if (got != expn) begin n_bad++; $display("FAIL drain_records: got %0d expected %0d", got, expn); end
        if (state !== 2'd0) begin n_bad++; $display("FAIL drain_end_state: got %0d expected 0", state); end
        if (count !== CW'(expn)) begin n_bad++; $display("FAIL drain_count_hold: got %0d expected %0d", count, expn); end
    endtask

    task automatic test_basic();
        logic [15:0] ts;
        arm = 1'b1;
        step();
        arm = 1'b0;
        n_cmp++;
        if (state !== 2'd1) begin n_bad++; $display("FAIL basic_armed: got %0d expected 1", state); end
        repeat (4) begin rand_lanes(2'b11); step(); end
        rand_lanes(2'b11);
        trig = 1'b1;
        ts = m_stamp;
        step();
        trig = 1'b0;
        repeat (3) begin rand_lanes(2'b11); step(); end
        n_cmp += 4;
        if (state !== 2'd3) begin n_bad++; $display("FAIL basic_state: got %0d expected 3", state); end
        if (count !== CW'(8)) begin n_bad++; $display("FAIL basic_count: got %0d expected 8", count); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL basic_overflow: got %0b expected 0", overflow); end
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency: got %0b expected 0", rd_valid); end
        test_drain(0, ts, 4);
    endtask

    task automatic test_overflow();
        logic [15:0] ts;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (20) begin rand_lanes(LANES'($urandom)); step(); end
        rand_lanes(LANES'($urandom));
        trig = 1'b1;
        ts = m_stamp;
        step();
        trig = 1'b0;
        repeat (3) begin rand_lanes(LANES'($urandom)); step(); end
        n_cmp += 3;
        if (state !== 2'd3) begin n_bad++; $display("FAIL ovf_state: got %0d expected 3", state); end
        if (count !== CW'(8)) begin n_bad++; $display("FAIL ovf_count: got %0d expected 8", count); end
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        n_cmp++;
        if (q[0][RW-1 -: 16] !== ts - 16'd4) begin n_bad++; $display("FAIL ovf_model_oldest: got %0h expected %0h", q[0][RW-1 -: 16], ts - 16'd4); end
        test_drain(0, ts, 4);
    endtask

    task automatic test_filter();
        logic [15:0] ts;
        int k;
        filter_en = 1'b1;
        rand_lanes(2'b00);
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_lanes(i[0] ? 2'b00 : 2'b01);
            step();
        end
        rand_lanes(2'b00);
        trig = 1'b1;
        ts = m_stamp;
        step();
        trig = 1'b0;
        k = 0;
        while (m_state != 3 && k < 20) begin
            rand_lanes(k[0] ? 2'b00 : 2'b01);
            step();
            k++;
        end
        n_cmp += 4;
        if (state !== 2'd3) begin n_bad++; $display("FAIL filter_state: got %0d expected 3", state); end
        if (count !== CW'(7)) begin n_bad++; $display("FAIL filter_count: got %0d expected 7", count); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL filter_overflow: got %0b expected 0", overflow); end
        if (k != 5) begin n_bad++; $display("FAIL filter_post_cycles: got %0d expected 5", k); end
        filter_en = 1'b0;
        test_drain(0, ts, 3);
    endtask

    task automatic test_abort();
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (2) begin rand_lanes(2'b10); step(); end
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        n_cmp++;
        if (state !== 2'd2) begin n_bad++; $display("FAIL abort_pre_post: got %0d expected 2", state); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp += 3;
        if (state !== 2'd0) begin n_bad++; $display("FAIL abort_state: got %0d expected 0", state); end
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL abort_rd_valid: got %0b expected 0", rd_valid); end
        if (count !== CW'(4)) begin n_bad++; $display("FAIL abort_count: got %0d expected 4", count); end
        rd_ready = 1'b1;
        repeat (3) begin
            step();
            n_cmp++;
            if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL abort_idle_valid: got %0b expected 0", rd_valid); end
        end
        rd_ready = 1'b0;
        arm = 1'b1;
        abort = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b0;
        n_cmp += 2;
        if (state !== 2'd0) begin n_bad++; $display("FAIL arm_abort_state: got %0d expected 0", state); end
        if (count !== CW'(q.size())) begin n_bad++; $display("FAIL arm_abort_count: got %0d expected %0d", count, q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ts;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (3) begin rand_lanes(LANES'($urandom)); step(); end
        rand_lanes(LANES'($urandom));
        trig = 1'b1;
        ts = m_stamp;
        step();
        trig = 1'b0;
        repeat (3) begin rand_lanes(LANES'($urandom)); step(); end
        n_cmp += 2;
        if (state !== 2'd3) begin n_bad++; $display("FAIL b2b_state: got %0d expected 3", state); end
        if (count !== CW'(7)) begin n_bad++; $display("FAIL b2b_count: got %0d expected 7", count); end
        test_drain(1, ts, 3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_filter();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
